// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (C) and the
// loader/debug path (L); registered memory strobes and fixed-latency read return.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
      $fatal(1, "mem_port_arbiter: MEM_LATENCY must be in 1..7");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t     state;
   logic       last_grant;   // 1 = loader was granted most recently
   logic [2:0] lat_cnt;
   logic       any_req;
   logic       pick_l;

   // Handshake: a requester holds req and payload until it sees its one-cycle
   // gnt; req still high on the following cycle counts as a fresh request.
   // Requests are only sampled in IDLE and RESP.
   assign any_req   = c_req | l_req;
   assign pick_l    = l_req & (~c_req | ~last_grant);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_cnt    <= 3'd0;
         c_gnt      <= 1'b0;
         l_gnt      <= 1'b0;
         c_rvalid   <= 1'b0;
         l_rvalid   <= 1'b0;
         c_rdata    <= '0;
         l_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         c_gnt    <= 1'b0;
         l_gnt    <= 1'b0;
         c_rvalid <= 1'b0;
         l_rvalid <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (any_req) begin
                  state      <= ACCESS;
                  busy       <= 1'b1;
                  mem_en     <= 1'b1;
                  last_grant <= pick_l;
                  if (pick_l) begin
                     l_gnt     <= 1'b1;
                     mem_we    <= l_we;
                     mem_addr  <= l_addr;
                     mem_wdata <= l_wdata;
                  end else begin
                     c_gnt     <= 1'b1;
                     mem_we    <= c_we;
                     mem_addr  <= c_addr;
                     mem_wdata <= c_wdata;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ACCESS: begin
               // mem_we still holds the direction of the access being issued
               if (mem_we) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state   <= WAIT;
                  lat_cnt <= 3'(MEM_LATENCY - 1);
               end
            end
            WAIT: begin
               if (lat_cnt == 3'd0) begin
                  state <= RESP;
                  if (last_grant) begin
                     l_rdata  <= mem_rdata;
                     l_rvalid <= 1'b1;
                  end else begin
                     c_rdata  <= mem_rdata;
                     c_rvalid <= 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle core between two requesters: the core's fetch/load/store path (port C) and the program loader/debug path (port L).
- Serialises accesses with a round-robin FSM, drives the memory with registered outputs, and times read returns against a fixed memory read latency.
- Sits between the core datapath address mux and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held with payload until c_gnt seen.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: core request issued to memory.
- c_rvalid  out  1  one-cycle pulse: c_rdata valid.
- c_rdata  out  DATA_W  core read data; holds until next core read return.
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: same as the c_* ports, for the loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable (only with mem_en).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0, including the rdata registers; last_grant=L, so the core wins the first tie. Any in-flight transaction is dropped and no rvalid is produced.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- Arbitration happens only in IDLE and RESP:
  - Single requester: it wins.
  - Both requesting: the winner is the port not in last_grant.
  - On the decision edge: state<=ACCESS, winner's gnt<=1, mem_addr/mem_we/mem_wdata<=winner payload, mem_en<=1, last_grant<=winner.
- ACCESS (exactly 1 cycle): mem_en=1, gnt=1.
  - Write: next state IDLE, or ACCESS again is not possible.
  - Read: next state WAIT, lat_cnt<=MEM_LATENCY-1.
- WAIT: lasts MEM_LATENCY cycles; lat_cnt decrements each cycle. In the cycle lat_cnt==0, mem_rdata is captured into the granted port's rdata register; next state RESP.
- RESP (1 cycle): granted port's rvalid=1. Arbitrates like IDLE; with no request, next state IDLE.
- Outside ACCESS: mem_en=0, mem_we=0, mem_addr/mem_wdata hold their last value. gnt and rvalid are 0 except as above.
- Requests seen in ACCESS/WAIT are not sampled; they stay pending, since requesters hold req.
- Requesters deassert req, or present a new request, starting the cycle after their gnt. A req still high then is treated as a new request.
- Timing, with request first seen in IDLE at cycle T and L=MEM_LATENCY:
  - gnt/mem_en at T+1.
  - Read rvalid at T+L+2.
  - Write returns to IDLE at T+2.
  - Back-to-back reads from RESP: next mem_en one cycle after RESP.
- No starvation: under continuous requests from both ports, grants strictly alternate.
- The MEM_LATENCY range is checked at elaboration; out-of-range values are a fatal error.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, busy=0. Release reset -> still 0 until a req arrives.
- Core read, MEM_LATENCY=2: c_req at T with c_addr=0x10; memory model returns 0xDEADBEEF two cycles after mem_en -> c_gnt and mem_en at T+1 with mem_addr=0x10, mem_we=0; c_rvalid at T+4 with c_rdata=0xDEADBEEF; c_rdata holds afterwards.
- Simultaneous read requests after reset -> core granted first, then loader granted on the cycle after core's RESP. Repeat both requests -> order C,L,C,L.
- Loader write 0x0000_00AA to 0x200 raised during a core read's WAIT -> no l_gnt before core RESP. mem_en/mem_we=1 with addr 0x200 in the cycle after RESP. No l_rvalid.
- Reset asserted in WAIT of a loader read -> outputs 0 immediately. After release: no l_rvalid, l_rdata=0, state IDLE.
- MEM_LATENCY=1 and 7 builds: single read -> rvalid at T+3 and T+9 respectively; mem_rdata is captured only in the last WAIT cycle, so changing it earlier has no effect.
